clock_gen: RTL and testbench

CLOCK_GEN -- requirements
Module: clock_gen

---
 rtl/clock_gen_pkg.sv | 11 +
 rtl/clock_gen.sv | 75 +++++++
 tb/tb_clock_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared constants and half-period helper for clock_gen
package clock_gen_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int CNT_W_DEF = (1 << SEL_W_DEF) - 1;

  function automatic longint half_period(input int sel);
    return longint'(1) << sel;
  endfunction

endpackage

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - glitch-free power-of-two clock divider with registered rise strobe
// Optional freeze-low stop control is built only when CLOCK_GEN_STOP_EN is defined.
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [SEL_W-1:0] clk_sel,
  input  logic             stop_clk,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             clk_stopped,
  output logic [SEL_W-1:0] sel_active
);

  localparam int CNT_W = (1 << SEL_W) - 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_last;

  assign h_last = CNT_W'(half_period(int'(sel_active)) - 1);

`ifdef CLOCK_GEN_STOP_EN
  logic stopped;
  assign clk_stopped = stopped;
`else
  logic stop_unused;
  assign stop_unused = stop_clk;
  assign clk_stopped = 1'b0;
`endif

  // sel_active only moves at the high->low boundary (or while frozen), so a
  // period in flight always completes with the length it started with.
  always_ff @(posedge clk) begin
    clk_rise <= 1'b0;
    if (arst) begin
      clk_out    <= 1'b0;
      cnt        <= '0;
      sel_active <= clk_sel;
`ifdef CLOCK_GEN_STOP_EN
      stopped    <= 1'b0;
`endif
    end
`ifdef CLOCK_GEN_STOP_EN
    else if (stopped) begin
      clk_out    <= 1'b0;
      cnt        <= '0;
      sel_active <= clk_sel;
      stopped    <= stop_clk;
    end
`endif
    else if (cnt == h_last) begin
      cnt <= '0;
      if (clk_out) begin
        clk_out    <= 1'b0;
        sel_active <= clk_sel;
      end
`ifdef CLOCK_GEN_STOP_EN
      else if (stop_clk) begin
        stopped    <= 1'b1;
        sel_active <= clk_sel;
      end
`endif
      else begin
        clk_out  <= 1'b1;
        clk_rise <= 1'b1;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - self-checking bench for clock_gen (both CLOCK_GEN_STOP_EN builds)
module tb_clock_gen;

  logic       clk;
  logic       arst;
  logic [2:0] clk_sel;
  logic       stop_clk;
  logic       clk_out;
  logic       clk_rise;
  logic       clk_stopped;
  logic [2:0] sel_active;

  clock_gen #(.SEL_W(3)) dut (
    .clk         (clk),
    .arst        (arst),
    .clk_sel     (clk_sel),
    .stop_clk    (stop_clk),
    .clk_out     (clk_out),
    .clk_rise    (clk_rise),
    .clk_stopped (clk_stopped),
    .sel_active  (sel_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       out;
    logic       rise;
    logic       stopped;
    logic [2:0] sel;
  } obs_t;

  typedef struct {
    logic [2:0] sel;
    int         half;
    string      name;
  } vec_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Expected outputs j edges after a period origin (reset edge, stop release,
  // or a high->low boundary): low for h edges, high for h edges, repeat.
  function automatic obs_t model(input int j, input int h, input logic st, input logic [2:0] s);
    obs_t o;
    o.out     = ((j / h) % 2) == 1;
    o.rise    = (j % (2 * h)) == h;
    o.stopped = st;
    o.sel     = s;
    return o;
  endfunction

  task automatic tick(input obs_t e, input string name);
    obs_t a;
    obs_t w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a = '{clk_out, clk_rise, clk_stopped, sel_active};
    w = exp_q.pop_front();
    tests++;
    if (a !== w) begin
      fails++;
      $display("FAIL %s: got out=%b rise=%b stopped=%b sel=%0d, want out=%b rise=%b stopped=%b sel=%0d",
               name, a.out, a.rise, a.stopped, a.sel, w.out, w.rise, w.stopped, w.sel);
    end
  endtask

  task automatic do_reset(input logic [2:0] s);
    arst     = 1'b1;
    clk_sel  = s;
    stop_clk = 1'b0;
    for (int i = 0; i < 5; i++)
      tick(model(0, 1, 1'b0, s), $sformatf("reset sel=%0d c=%0d", s, i));
    arst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    obs_t e;
    arst     = 1'b1;
    clk_sel  = 3'd0;
    stop_clk = 1'b0;

    vecs[0] = '{3'd0, 1,   "div2"};
    vecs[1] = '{3'd1, 2,   "div4"};
    vecs[2] = '{3'd3, 8,   "div16"};
    vecs[3] = '{3'd7, 128, "div256"};
    vecs[4] = '{3'd2, 4,   "div8"};

    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].sel);
      for (int k = 1; k <= 4 * vecs[v].half + 2; k++)
        tick(model(k, vecs[v].half, 1'b0, vecs[v].sel), $sformatf("%s k=%0d", vecs[v].name, k));
    end

    // select 3 -> 1 while high: current period still 16, then 4-cycle periods
    do_reset(3'd3);
    for (int k = 1; k <= 40; k++) begin
      if (k < 16) e = model(k, 8, 1'b0, 3'd3);
      else        e = model(k - 16, 2, 1'b0, 3'd1);
      tick(e, $sformatf("selchg k=%0d", k));
      if (k == 10) clk_sel = 3'd1;
    end

`ifdef CLOCK_GEN_STOP_EN
    // stop requested while high, select changed while frozen, then released
    do_reset(3'd2);
    for (int k = 1; k <= 30; k++) begin
      if (k < 8)       e = model(k, 4, 1'b0, 3'd2);
      else if (k < 12) e = '{1'b0, 1'b0, 1'b0, 3'd2};
      else if (k < 16) e = '{1'b0, 1'b0, 1'b1, (k < 14) ? 3'd2 : 3'd1};
      else             e = model(k - 16, 2, 1'b0, 3'd1);
      tick(e, $sformatf("stop k=%0d", k));
      if (k == 5)  stop_clk = 1'b1;
      if (k == 13) clk_sel  = 3'd1;
      if (k == 15) stop_clk = 1'b0;
    end
`else
    // stop input has no effect in this build
    do_reset(3'd2);
    for (int k = 1; k <= 30; k++) begin
      tick(model(k, 4, 1'b0, 3'd2), $sformatf("nostop k=%0d", k));
      if (k == 5) stop_clk = 1'b1;
    end
    stop_clk = 1'b0;
`endif

    // one-cycle reset pulse in the middle of a high phase
    do_reset(3'd4);
    for (int k = 1; k <= 60; k++) begin
      if (k < 21) e = model(k, 16, 1'b0, 3'd4);
      else        e = model(k - 21, 16, 1'b0, 3'd4);
      tick(e, $sformatf("midrst k=%0d", k));
      if (k == 20) arst = 1'b1;
      if (k == 21) arst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
